lsen_i2c_arbiter: RTL and testbench
===================================

# lsen_i2c_arbiter

Round-robin arbiter and sequencer that shares one I2C byte-transaction engine between several register-access requesters (light-sensor controller, board-management poller, debug port). Each requester posts one transaction: a write byte or read byte to a pointer register. The arbiter grants one requester at a time, drives the engine through a GO/END handshake, and returns read data and an ACK error status. A timeout recovers from a hung engine, and a guard gap lets the engine return to idle between transactions. It sits between the requesters and the engine, in the CLK_50 domain.

## Interface
- NUM_REQ, 3: number of requesters (2..8).
- TIMEOUT_CYC, 20000: CLK_50 cycles allowed in WAIT before abort (16-bit).
- GAP_CYC, 250: idle cycles with ENG_GO low after each transaction (16-bit, ≥1).
- CLK_50  in  1  sole clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ  in  NUM_REQ  per-requester request level.
- REQ_RW  in  NUM_REQ  1 = read, 0 = write.
- REQ_PTR  in  8*NUM_REQ  pointer register; requester i uses bits [8i+7:8i].
- REQ_WDATA  in  8*NUM_REQ  write data, packed as REQ_PTR.
- GNT  out  NUM_REQ  one-hot grant.
- DONE  out  NUM_REQ  one-cycle completion pulse.
- RDATA  out  8  read data of the last completed read.
- ERR  out  1  error status of the last completed transaction (NACK or timeout).
- ERR_CNT  out  8  saturating count of errored transactions.
- ENG_GO  out  1  engine start level.
- ENG_RW, ENG_PTR[7:0], ENG_WDATA[7:0]  out  transaction fields to the engine.
- ENG_END  in  1  engine done level (CLK_400K domain; asynchronous here).
- ENG_ACK_OK  in  1  engine ACK status; stable while ENG_END is high.
- ENG_RDATA  in  8  engine read data; stable while ENG_END is high.

## Operation
- States: IDLE, WAIT, GAP.
- Reset values:
  - state IDLE; all outputs 0.
  - round-robin pointer LAST = NUM_REQ-1, so requester 0 has first priority.
  - synchronizer flops 0.
- ENG_END passes through a 2-flop synchronizer plus an edge register. end_rise = synced high && previous synced low.
- IDLE, on an edge where any REQ bit is high:
  - Winner w = first set bit searching LAST+1, LAST+2, … modulo NUM_REQ.
  - GNT[w] is set.
  - ENG_RW, ENG_PTR and ENG_WDATA are loaded from slot w.
  - ENG_GO is set to 1, LAST is set to w, the timeout counter is cleared, and the state moves to WAIT.
- WAIT:
  - The timeout counter increments every cycle.
  - On end_rise:
    - ENG_GO, GNT and DONE[w] are set to 0, 0 and 1 respectively.
    - If the transaction was a read, RDATA is loaded from ENG_RDATA; writes leave RDATA unchanged.
    - ERR is set to ~ENG_ACK_OK, and ERR_CNT increments (saturating at 255) if that is set.
    - The state moves to GAP.
  - If the counter reaches TIMEOUT_CYC-1 without end_rise, the same exit applies with ERR = 1. RDATA is unchanged.
- GAP:
  - DONE returns to 0 after one cycle.
  - A counter runs GAP_CYC cycles, then the state moves to IDLE.
  - REQ is ignored during GAP.
- Requester rules:
  - Hold REQ and that slot's fields stable from REQ assertion until the DONE pulse is seen.
  - Drop REQ on the cycle DONE is seen. REQ still high at the return to IDLE is treated as a new request.
- Dropping REQ while granted does not abort: the transaction completes and DONE still pulses.
- The engine fields stay latched through WAIT. They are don't-care in IDLE/GAP but hold their last value.
- ENG_END already high on entry to WAIT produces no end_rise. Only the timeout ends such a transaction.

## Timing
- Grant latency: REQ sampled high at edge k gives GNT and ENG_GO high after edge k, with the state in IDLE.
- End latency: ENG_END rising between edges n-1 and n produces end_rise at edge n+2. DONE is high for the cycle after edge n+2.
- Minimum spacing between ENG_GO rises: 1 + GAP_CYC + 1 cycles beyond engine time.
- Simultaneous REQ bits: exactly one grant, by round-robin order. Under continuous demand from all requesters, service order is 0,1,2,0,…
- A requester asserting REQ during WAIT or GAP waits for the next IDLE. It is never lost while REQ is held.
- Reset mid-operation (RESET_N low in any state): ENG_GO, GNT and DONE drop immediately (asynchronously). The state returns to IDLE, ERR_CNT clears, and no DONE is emitted for the aborted transaction.
- ERR and RDATA hold their values until the next completion overwrites them.

## Test plan
- Single read: REQ[1]=1, RW=1, PTR=8'h26, model returns ENG_RDATA=8'h5A with ACK_OK=1 -> GNT=3'b010, ENG_PTR=8'h26, one DONE[1] pulse, RDATA=8'h5A, ERR=0.
- Contention: REQ=3'b111 held, requesters re-requesting immediately after DONE -> grant order 0,1,2,0. Each ENG_GO rise separated by ≥GAP_CYC+2 cycles.
- NACK write: REQ[0] write PTR=8'h07, WDATA=8'h17, model ACK_OK=0 -> DONE[0], ERR=1, ERR_CNT=1, RDATA unchanged.
- Timeout: model never raises ENG_END -> DONE pulses TIMEOUT_CYC cycles after GNT, ERR=1, ENG_GO=0; the arbiter returns to IDLE after GAP.
- Stale END: ENG_END held high before the grant -> no DONE until timeout. ERR_CNT saturates at 255 after 300 such timeouts.
- Reset in WAIT: assert RESET_N=0 mid-transaction -> all outputs 0 asynchronously, no DONE. After release, REQ[2] alone is granted first cycle-correctly.

Source files
------------

// File: rtl/lsen_i2c_arbiter.sv
// lsen_i2c_arbiter: round-robin arbiter that shares one I2C byte engine
// between NUM_REQ register-access requesters, with a GO/END handshake,
// a WAIT timeout and an idle guard gap between transactions.
`timescale 1ns/1ps

module lsen_i2c_arbiter #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned TIMEOUT_CYC = 20000,
  parameter int unsigned GAP_CYC     = 250
) (
  input  logic                   i_clk_50,
  input  logic                   i_reset_n,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [NUM_REQ-1:0]     i_req_rw,
  input  logic [8*NUM_REQ-1:0]   i_req_ptr,
  input  logic [8*NUM_REQ-1:0]   i_req_wdata,
  output logic [NUM_REQ-1:0]     o_gnt,
  output logic [NUM_REQ-1:0]     o_done,
  output logic [7:0]             o_rdata,
  output logic                   o_err,
  output logic [7:0]             o_err_cnt,
  output logic                   o_eng_go,
  output logic                   o_eng_rw,
  output logic [7:0]             o_eng_ptr,
  output logic [7:0]             o_eng_wdata,
  input  logic                   i_eng_end,
  input  logic                   i_eng_ack_ok,
  input  logic [7:0]             i_eng_rdata
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_last;
  logic [15:0]      r_tmo;
  logic [15:0]      r_gap;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_end_d;

  logic             w_end_rise;
  logic             w_any;
  logic [IDX_W-1:0] w_win;
  logic             w_rw;
  logic [7:0]       w_ptr;
  logic [7:0]       w_wdata;

  // Rising edge of the synchronized engine END level
  assign w_end_rise = r_sync2 & ~r_end_d;

  // Round-robin search starting just after the last winner
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!w_any && i_req[IDX_W'((32'(r_last) + i) % NUM_REQ)]) begin
        w_any = 1'b1;
        w_win = IDX_W'((32'(r_last) + i) % NUM_REQ);
      end
    end
  end

  // Transaction fields of the winning slot
  always_comb begin
    w_rw    = i_req_rw[w_win];
    w_ptr   = 8'(i_req_ptr >> {w_win, 3'b000});
    w_wdata = 8'(i_req_wdata >> {w_win, 3'b000});
  end

  // Synchronizer, sequencer FSM and registered outputs
  always_ff @(posedge i_clk_50 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_last      <= IDX_W'(NUM_REQ - 1);
      r_tmo       <= '0;
      r_gap       <= '0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_end_d     <= 1'b0;
      o_gnt       <= '0;
      o_done      <= '0;
      o_rdata     <= '0;
      o_err       <= 1'b0;
      o_err_cnt   <= '0;
      o_eng_go    <= 1'b0;
      o_eng_rw    <= 1'b0;
      o_eng_ptr   <= '0;
      o_eng_wdata <= '0;
    end else begin
      r_sync1 <= i_eng_end;
      r_sync2 <= r_sync1;
      r_end_d <= r_sync2;
      o_done  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            o_gnt       <= NUM_REQ'(1) << w_win;
            o_eng_rw    <= w_rw;
            o_eng_ptr   <= w_ptr;
            o_eng_wdata <= w_wdata;
            o_eng_go    <= 1'b1;
            r_last      <= w_win;
            r_tmo       <= '0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_end_rise || (r_tmo == 16'(TIMEOUT_CYC - 1))) begin
            o_eng_go <= 1'b0;
            o_gnt    <= '0;
            o_done   <= NUM_REQ'(1) << r_last;
            if (w_end_rise) begin
              if (o_eng_rw) begin
                o_rdata <= i_eng_rdata;
              end
              o_err <= ~i_eng_ack_ok;
              if (!i_eng_ack_ok && (o_err_cnt != 8'hFF)) begin
                o_err_cnt <= o_err_cnt + 8'd1;
              end
            end else begin
              o_err <= 1'b1;
              if (o_err_cnt != 8'hFF) begin
                o_err_cnt <= o_err_cnt + 8'd1;
              end
            end
            r_gap   <= '0;
            r_state <= ST_GAP;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        ST_GAP: begin
          if (r_gap == 16'(GAP_CYC - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsen_i2c_arbiter.sv
// Testbench for lsen_i2c_arbiter: directed stimulus with grant/completion
// scoreboards drained by a negedge monitor, plus a behavioural engine model.
`timescale 1ns/1ps

module tb_lsen_i2c_arbiter;

  localparam int unsigned NR  = 3;
  localparam int unsigned TMO = 40;
  localparam int unsigned GAP = 5;
  localparam int          LIM = 200;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR-1:0]   req_rw = '0;
  logic [8*NR-1:0] req_ptr = '0;
  logic [8*NR-1:0] req_wd = '0;
  logic [NR-1:0]   o_gnt, o_done;
  logic [7:0]      o_rdata, o_err_cnt, o_eng_ptr, o_eng_wdata;
  logic            o_err, o_eng_go, o_eng_rw;
  logic            eng_end = 1'b0;
  logic            eng_ack = 1'b1;
  logic [7:0]      eng_rd = 8'hC3;
  int              eng_mode = 0;   // 0: responds, 1: silent (hang or stale END)

  always #10 clk = ~clk;

  lsen_i2c_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
    .i_clk_50(clk), .i_reset_n(rst_n), .i_req(req), .i_req_rw(req_rw),
    .i_req_ptr(req_ptr), .i_req_wdata(req_wd), .o_gnt(o_gnt), .o_done(o_done),
    .o_rdata(o_rdata), .o_err(o_err), .o_err_cnt(o_err_cnt), .o_eng_go(o_eng_go),
    .o_eng_rw(o_eng_rw), .o_eng_ptr(o_eng_ptr), .o_eng_wdata(o_eng_wdata),
    .i_eng_end(eng_end), .i_eng_ack_ok(eng_ack), .i_eng_rdata(eng_rd)
  );

  typedef struct { logic [NR-1:0] gnt; logic rw; logic [7:0] ptr; logic [7:0] wd; } gexp_t;
  typedef struct { logic [NR-1:0] done; logic [7:0] rdata; logic err; logic [7:0] cnt; int lat; } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    gnt_cyc = 0;
  int    last_rise = -1;
  logic  go_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: raises END a few cycles after GO, drops it after GO falls
  initial begin
    forever begin
      @(negedge clk);
      if (eng_mode == 0 && o_eng_go && rst_n) begin
        repeat (2) @(negedge clk);
        #3 eng_end = 1'b1;
        while (o_eng_go) @(negedge clk);
        #3 eng_end = 1'b0;
      end
    end
  end

  // Monitor: pops grant expectations on GO rise, completion expectations on DONE
  always @(negedge clk) begin
    gexp_t g;
    dexp_t d;
    if (!rst_n) begin
      last_rise = -1;
    end else begin
      if (o_eng_go && !go_prev) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", 32'(o_gnt), 32'(0));
        end else begin
          g = gq.pop_front();
          chk("gnt", 32'(o_gnt), 32'(g.gnt));
          chk("eng_ptr", 32'(o_eng_ptr), 32'(g.ptr));
          chk("eng_rw", 32'(o_eng_rw), 32'(g.rw));
          if (!g.rw) chk("eng_wdata", 32'(o_eng_wdata), 32'(g.wd));
        end
        if (last_rise >= 0) chk("go_spacing_ok", 32'((cyc - last_rise) >= int'(GAP + 2)), 32'(1));
        last_rise = cyc;
        gnt_cyc   = cyc;
      end
      if (o_done != '0) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'(o_done), 32'(0));
        end else begin
          d = dq.pop_front();
          chk("done", 32'(o_done), 32'(d.done));
          chk("rdata", 32'(o_rdata), 32'(d.rdata));
          chk("err", 32'(o_err), 32'(d.err));
          chk("err_cnt", 32'(o_err_cnt), 32'(d.cnt));
          chk("go_low_at_done", 32'(o_eng_go), 32'(0));
          chk("gnt_low_at_done", 32'(o_gnt), 32'(0));
          if (d.lat != 0) chk("timeout_latency", 32'(cyc - gnt_cyc), 32'(d.lat));
        end
      end
    end
    go_prev = o_eng_go;
  end

  task automatic set_slot(input int i, input logic rw, input logic [7:0] p, input logic [7:0] w);
    req_rw[i]         = rw;
    req_ptr[8*i +: 8] = p;
    req_wd[8*i +: 8]  = w;
  endtask

  task automatic push_g(input int i, input logic rw, input logic [7:0] p, input logic [7:0] w);
    gexp_t g;
    g.gnt = NR'(1) << i; g.rw = rw; g.ptr = p; g.wd = w;
    gq.push_back(g);
  endtask

  task automatic push_d(input int i, input logic [7:0] rd, input logic e, input logic [7:0] c, input int lat);
    dexp_t d;
    d.done = NR'(1) << i; d.rdata = rd; d.err = e; d.cnt = c; d.lat = lat;
    dq.push_back(d);
  endtask

  task automatic wait_done(input int i, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!o_done[i] && n < LIM);
    chk({nm, "_done_seen"}, 32'(o_done[i]), 32'(1));
  endtask

  task automatic wait_go(input string nm);
    int n = 0;
    while (!o_eng_go && n < LIM) begin @(negedge clk); n++; end
    chk({nm, "_go_seen"}, 32'(o_eng_go), 32'(1));
  endtask

  task automatic settle();
    repeat (GAP + 6) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ord[4];
    logic [7:0] exp_cnt;
    ord = '{0, 1, 2, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_go", 32'(o_eng_go), 32'(0));
    chk("rst_gnt", 32'(o_gnt), 32'(0));
    chk("rst_done", 32'(o_done), 32'(0));
    chk("rst_err", 32'(o_err), 32'(0));
    chk("rst_err_cnt", 32'(o_err_cnt), 32'(0));
    chk("rst_rdata", 32'(o_rdata), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Contention: all three request, order 0,1,2,0
    for (int i = 0; i < 3; i++) set_slot(i, 1'b1, 8'h10 + 8'(i), 8'hA0 + 8'(i));
    for (int n = 0; n < 4; n++) begin
      push_g(ord[n], 1'b1, 8'h10 + 8'(ord[n]), 8'hA0 + 8'(ord[n]));
      push_d(ord[n], 8'hC3, 1'b0, 8'd0, 0);
    end
    req = 3'b111;
    for (int n = 0; n < 3; n++) begin
      wait_done(ord[n], "contend");
      req[ord[n]] = 1'b0;
      @(negedge clk);
      req[ord[n]] = 1'b1;
    end
    wait_go("contend_last");
    req = 3'b001;
    wait_done(0, "contend_last");
    req = '0;
    settle();

    // Single read on requester 1
    eng_rd = 8'h5A;
    set_slot(1, 1'b1, 8'h26, 8'h00);
    push_g(1, 1'b1, 8'h26, 8'h00);
    push_d(1, 8'h5A, 1'b0, 8'd0, 0);
    req[1] = 1'b1;
    wait_done(1, "read");
    req[1] = 1'b0;
    settle();

    // NACKed write on requester 0: RDATA must not change
    eng_ack = 1'b0;
    eng_rd  = 8'hEE;
    set_slot(0, 1'b0, 8'h07, 8'h17);
    push_g(0, 1'b0, 8'h07, 8'h17);
    push_d(0, 8'h5A, 1'b1, 8'd1, 0);
    req[0] = 1'b1;
    wait_done(0, "nack");
    req[0] = 1'b0;
    settle();
    eng_ack = 1'b1;

    // Timeout: engine never answers
    eng_mode = 1;
    set_slot(2, 1'b1, 8'h33, 8'h00);
    push_g(2, 1'b1, 8'h33, 8'h00);
    push_d(2, 8'h5A, 1'b1, 8'd2, TMO);
    req[2] = 1'b1;
    wait_done(2, "timeout");
    req[2] = 1'b0;
    settle();

    // Stale END held high: every transaction times out, ERR_CNT saturates
    eng_end = 1'b1;
    repeat (5) @(negedge clk);
    set_slot(0, 1'b1, 8'h44, 8'h00);
    for (int k = 0; k < 300; k++) begin
      exp_cnt = (k + 3 > 255) ? 8'd255 : 8'(k + 3);
      push_g(0, 1'b1, 8'h44, 8'h00);
      push_d(0, 8'h5A, 1'b1, exp_cnt, TMO);
      req[0] = 1'b1;
      wait_done(0, "stale");
      req[0] = 1'b0;
      @(negedge clk);
    end
    eng_end = 1'b0;
    settle();

    // Reset in WAIT: outputs clear asynchronously, no DONE for the victim
    set_slot(1, 1'b1, 8'h55, 8'h00);
    push_g(1, 1'b1, 8'h55, 8'h00);
    req[1] = 1'b1;
    wait_go("rstwait");
    repeat (10) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_go", 32'(o_eng_go), 32'(0));
    chk("async_rst_gnt", 32'(o_gnt), 32'(0));
    chk("async_rst_done", 32'(o_done), 32'(0));
    chk("async_rst_err_cnt", 32'(o_err_cnt), 32'(0));
    chk("async_rst_err", 32'(o_err), 32'(0));
    chk("async_rst_rdata", 32'(o_rdata), 32'(0));
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_slot(2, 1'b0, 8'h66, 8'h99);
    push_g(2, 1'b0, 8'h66, 8'h99);
    push_d(2, 8'h00, 1'b1, 8'd1, TMO);
    @(negedge clk);
    req[2] = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt_latency", 32'(o_gnt), 32'(3'b100));
    chk("post_rst_go_latency", 32'(o_eng_go), 32'(1));
    wait_done(2, "post_rst");
    req[2] = 1'b0;
    settle();

    chk("grant_queue_drained", 32'(gq.size()), 32'(0));
    chk("done_queue_drained", 32'(dq.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
